// File: rtl/ksa_dec.sv
// Decryption-side PRESENT-80 key schedule: expands the master key forward, then replays round
// keys ROUNDS..1 over a valid/ready port. Optional macro KSA_DEC_KEY_CACHE_EN adds a one-entry cache.
module ksa_dec #(
    parameter int unsigned KEY_W  = 80,
    parameter int unsigned RK_W   = 64,
    parameter int unsigned ROUNDS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [RK_W-1:0]  rk_out,
    output logic [5:0]       rk_idx,
    output logic             done
);

    typedef enum logic [1:0] {StIdle, StExpand, StEmit, StDone} state_e;

    localparam logic [5:0] CntLast = 6'(ROUNDS - 1);
    localparam logic [5:0] CntFull = 6'(ROUNDS);

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
            4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
            4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
            4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Bit positions assume the 80-bit PRESENT key register.
    function automatic logic [KEY_W-1:0] ksa_fwd(input logic [KEY_W-1:0] k, input logic [4:0] c);
        logic [KEY_W-1:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ c;
        return r;
    endfunction

    function automatic logic [KEY_W-1:0] ksa_inv(input logic [KEY_W-1:0] k, input logic [4:0] c);
        logic [KEY_W-1:0] r;
        r          = k;
        r[19:15]   = r[19:15] ^ c;
        r[79:76]   = sbox_inv(r[79:76]);
        return {r[60:0], r[79:61]};
    endfunction

    state_e           state_q;
    logic [KEY_W-1:0] key_q;
    logic [5:0]       cnt_q;
    logic             busy_q;
    logic             valid_q;
    logic             done_q;

    logic [KEY_W-1:0] key_fwd;
    logic [KEY_W-1:0] key_inv;
    logic [5:0]       cnt_dec;
    logic             cache_hit;

    assign cnt_dec = cnt_q - 6'd1;
    assign key_fwd = ksa_fwd(key_q, cnt_q[4:0]);
    assign key_inv = ksa_inv(key_q, cnt_dec[4:0]);

`ifdef KSA_DEC_KEY_CACHE_EN
    logic [KEY_W-1:0] mkey_q;
    logic [KEY_W-1:0] tag_q;
    logic [KEY_W-1:0] cache_q;
    logic             cache_vld_q;

    assign cache_hit = cache_vld_q && (key_in == tag_q);
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            key_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
`ifdef KSA_DEC_KEY_CACHE_EN
            mkey_q      <= '0;
            tag_q       <= '0;
            cache_q     <= '0;
            cache_vld_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && cache_hit) begin
`ifdef KSA_DEC_KEY_CACHE_EN
                        key_q <= cache_q;
`endif
                        cnt_q   <= CntFull;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= StEmit;
                    end else if (start) begin
`ifdef KSA_DEC_KEY_CACHE_EN
                        mkey_q <= key_in;
`endif
                        key_q   <= key_in;
                        cnt_q   <= 6'd1;
                        busy_q  <= 1'b1;
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    key_q <= key_fwd;
                    if (cnt_q == CntLast) begin
                        cnt_q   <= CntFull;
                        valid_q <= 1'b1;
                        state_q <= StEmit;
`ifdef KSA_DEC_KEY_CACHE_EN
                        tag_q       <= mkey_q;
                        cache_q     <= key_fwd;
                        cache_vld_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StEmit: begin
                    if (rk_ready) begin
                        if (cnt_q > 6'd1) begin
                            key_q <= key_inv;
                            cnt_q <= cnt_dec;
                        end else begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end
                    end
                end
                StDone: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy     = busy_q;
    assign rk_valid = valid_q;
    assign done     = done_q;
    assign rk_out   = valid_q ? key_q[KEY_W-1 -: RK_W] : '0;
    assign rk_idx   = valid_q ? cnt_q : 6'd0;

endmodule

// File: doc/ksa_dec.md
Name: ksa_dec

Overview:
- Decryption-side key schedule, the reverse-direction counterpart of the forward KSA.
- Accepts the 80-bit master key and internally expands forward to the final key state.
- Then emits round keys in reverse order (ROUNDS down to 1), one per valid/ready handshake, to the decryption datapath.
- Uses the same PRESENT-80 style update as the forward schedule, so round key i here equals forward round key i.

Parameters:
- KEY_W, 80, key register width; only 80 is supported.
- RK_W, 64, round key width; round key = K[KEY_W-1:KEY_W-RK_W].
- ROUNDS, 32, number of round keys emitted; forward update counters run 1..ROUNDS-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new key sequence; sampled only in IDLE.
- key_in  input  KEY_W  master key; captured when start is accepted.
- busy  output  1  high in every state except IDLE.
- rk_valid  output  1  rk_out/rk_idx hold a valid round key.
- rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready.
- rk_out  output  RK_W  current round key.
- rk_idx  output  6  round number of rk_out (ROUNDS..1).
- done  output  1  one-cycle pulse after round key 1 is accepted.

Behaviour:
- Forward update with counter c:
  - K = K rotated left by 61.
  - K[79:76] = S(K[79:76]).
  - K[19:15] ^= c[4:0].
- S-box S = {C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2} for inputs 0..F.
- Inverse update with counter c:
  - K[19:15] ^= c[4:0].
  - K[79:76] = S^-1(K[79:76]).
  - K = K rotated right by 61.
- Reset: state=IDLE, K=0, cnt=0; busy=0, rk_valid=0, rk_out=0, rk_idx=0, done=0. Reset in any state aborts with no done pulse.
- IDLE:
  - On start, K<=key_in, cnt<=1, go to EXPAND.
  - start while busy is ignored and does not queue.
- EXPAND:
  - Each cycle, apply the forward update with cnt, then cnt++.
  - After the update with cnt=ROUNDS-1, cnt<=ROUNDS and go to EMIT.
  - Exactly 31 cycles. rk_valid goes high on the 32nd cycle after the start cycle.
- EMIT:
  - rk_valid=1, rk_out=K[79:16], rk_idx=cnt.
  - Outputs hold stable while rk_ready=0.
  - On handshake with cnt>1: apply the inverse update with cnt-1, cnt--; the next key is valid the very next cycle (full throughput).
  - On handshake with cnt==1: go to DONE.
- DONE: done=1 for one cycle, rk_valid=0, then IDLE. A start in DONE is ignored.
- Width rules:
  - Counter XOR uses the low 5 bits; ROUNDS-1=31 fits.
  - rk_idx is zero-extended cnt.
  - rk_out is 0 whenever rk_valid=0.

Optional Feature:
- Macro KSA_DEC_KEY_CACHE_EN.
- Defined:
  - On entering EMIT, store the master key in tag_q, the final K in cache_q, and set cache_vld.
  - A later start with key_in==tag_q and cache_vld=1 loads K<=cache_q and cnt<=ROUNDS, skipping EXPAND; rk_valid is high the cycle after start.
  - rst clears cache_vld. An aborted (reset) sequence never populates the cache.
- Undefined: no cache registers; every start takes the full 31-cycle EXPAND.

Test Plan:
- key_in=0, start, rk_ready=1 constantly -> rk_valid rises 32 cycles after start; rk_idx sequence 32,31,...,1 on consecutive cycles; rk_idx=2 gives rk_out=0xC000000000000000; rk_idx=1 gives rk_out=0; done pulses once; busy falls with done.
- key_in=0xFFFFFFFFFFFFFFFFFFFF -> final emitted key (rk_idx=1) is 0xFFFFFFFFFFFFFFFF; all 32 keys match the forward KSA golden model in reverse order.
- Random key, rk_ready toggled pseudo-randomly -> rk_out/rk_idx stable while stalled; no key lost or duplicated; exactly 32 handshakes; one done.
- rst asserted mid-EXPAND (cycle 10) and mid-EMIT (rk_idx=17) -> next cycle all outputs 0, busy=0, no done; a fresh start then yields a correct full sequence.
- start pulsed during EXPAND, EMIT and DONE -> ignored, sequence unchanged; start in the first IDLE cycle after done is accepted.
- With KSA_DEC_KEY_CACHE_EN: same key twice -> second rk_valid one cycle after start with identical keys; different key -> 31-cycle expand; after rst, same key -> 31-cycle expand. Without the macro: every start has 31-cycle latency.
